// File: rtl/counter_seq_ctrl.sv
// Command sequencer for an up/down counter: runs LOAD/UP/DOWN/WAIT commands,
// counts carry_out wraps and returns the final count in a held response.
module counter_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ARG_W  = 16,
    parameter int WRAP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ARG_W-1:0]  cmd_arg,
    input  logic              abort,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_val,
    output logic [WRAP_W-1:0] rsp_wraps,
    output logic              rsp_aborted,
    output logic [WIDTH-1:0]  ctr_in_val,
    output logic              ctr_load,
    output logic              ctr_up_down,
    output logic              ctr_count_en,
    input  logic [WIDTH-1:0]  ctr_out_val,
    input  logic              ctr_carry_out
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_WAIT = 2'b11} op_t;

    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    state_t             state;
    op_t                op;
    logic [ARG_W-1:0]   remaining;
    logic [WRAP_W-1:0]  wraps;
    logic               aborted;
    logic               load_q;
    logic               en_q;
    logic               up_q;
    logic               fresh;
    logic [WIDTH-1:0]   val_q;
    logic [WIDTH-1:0]   in_val_q;
    logic               exec_abort;

    // LOAD cannot be aborted; en_q is only ever set while in EXEC.
    assign exec_abort   = (state == EXEC) && abort && (op != OP_LOAD);
    assign ctr_count_en = en_q && !abort;

    assign ctr_load     = load_q;
    assign ctr_up_down  = up_q;
    assign ctr_in_val   = in_val_q;
    assign cmd_ready    = (state == IDLE);
    assign rsp_valid    = (state == DONE);
    assign rsp_wraps    = wraps;
    assign rsp_aborted  = aborted;
    // The counter updates on the edge that enters DONE, so its final value is only
    // visible during the first DONE cycle; pass it through then and hold it after.
    assign rsp_val      = fresh ? ctr_out_val : val_q;

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op        <= OP_LOAD;
            remaining <= '0;
            wraps     <= '0;
            aborted   <= 1'b0;
            load_q    <= 1'b0;
            en_q      <= 1'b0;
            up_q      <= 1'b0;
            fresh     <= 1'b0;
            val_q     <= '0;
            in_val_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op        <= op_t'(cmd_op);
                        remaining <= cmd_arg;
                        wraps     <= '0;
                        aborted   <= 1'b0;
                        if (op_t'(cmd_op) == OP_LOAD) begin
                            in_val_q <= cmd_arg[WIDTH-1:0];
                            load_q   <= 1'b1;
                            state    <= EXEC;
                        end else if (cmd_arg == '0) begin
                            fresh <= 1'b1;
                            state <= DONE;
                        end else begin
                            en_q  <= (op_t'(cmd_op) != OP_WAIT);
                            up_q  <= (op_t'(cmd_op) == OP_UP);
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (ctr_count_en && ctr_carry_out && wraps != WRAP_MAX)
                        wraps <= wraps + 1'b1;
                    if (load_q || exec_abort || remaining == ARG_W'(1)) begin
                        load_q  <= 1'b0;
                        en_q    <= 1'b0;
                        up_q    <= 1'b0;
                        aborted <= exec_abort;
                        fresh   <= 1'b1;
                        state   <= DONE;
                    end else begin
                        remaining <= remaining - 1'b1;
                    end
                end
                DONE: begin
                    fresh <= 1'b0;
                    if (fresh)
                        val_q <= ctr_out_val;
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: drives a behavioural up/down counter and checks
// responses and strobe timing against an arithmetic model of the command rules.
module tb_counter_seq_ctrl;

    localparam logic [1:0] LOAD = 2'b00, UP = 2'b01, DOWN = 2'b10, WAIT = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_arg = '0;
    logic        abort = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_val;
    logic [3:0]  rsp_wraps;
    logic        rsp_aborted;
    logic [7:0]  ctr_in_val;
    logic        ctr_load;
    logic        ctr_up_down;
    logic        ctr_count_en;
    logic [7:0]  ctr_out_val;
    logic        ctr_carry_out;

    int total = 0;
    int bad   = 0;

    counter_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .abort(abort),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_val(rsp_val),
        .rsp_wraps(rsp_wraps), .rsp_aborted(rsp_aborted),
        .ctr_in_val(ctr_in_val), .ctr_load(ctr_load), .ctr_up_down(ctr_up_down),
        .ctr_count_en(ctr_count_en), .ctr_out_val(ctr_out_val), .ctr_carry_out(ctr_carry_out)
    );

    always #5 clk = ~clk;

    // Counter datapath the sequencer talks to.
    logic [7:0] cval;
    always @(posedge clk) begin
        if (rst)               cval <= 8'h00;
        else if (ctr_load)     cval <= ctr_in_val;
        else if (ctr_count_en) cval <= ctr_up_down ? cval + 8'd1 : cval - 8'd1;
    end
    assign ctr_out_val   = cval;
    assign ctr_carry_out = ctr_count_en && (ctr_up_down ? (cval == 8'hFF) : (cval == 8'h00));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    // Number of all-ones (up) or zero (down) values passed through over n steps from v.
    function automatic int wraps_for(input logic [1:0] op, input int v, input int n);
        int th, w;
        th = (op == UP) ? 255 - v : v;
        w  = (n > th) ? 1 + (n - 1 - th) / 256 : 0;
        return (w > 15) ? 15 : w;
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [15:0] arg;
        int          abort_at;
        int          ready_delay;
        logic [7:0]  val;
        logic [3:0]  wraps;
        logic        aborted;
        int          strobes;
        int          done;
    } vec_t;

    task automatic run_cmd(input string tag, input vec_t v);
        int c, strobes, loads, viol;
        bit done;
        logic [12:0] snap;
        strobes = 0; loads = 0; viol = 0; done = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = v.op; cmd_arg = v.arg;
        @(negedge clk);
        check({tag, ".ready"}, cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_arg = 16'($urandom);
        c = 1;
        while (!done && c <= 5000) begin
            abort = (c == v.abort_at);
            @(negedge clk);
            if (ctr_count_en) strobes++;
            if (ctr_load) begin
                loads++;
                if (ctr_in_val != v.arg[7:0]) viol++;
            end
            if (ctr_load && ctr_count_en) viol++;
            if (ctr_up_down && v.op != UP) viol++;
            if (ctr_count_en && ctr_up_down != (v.op == UP)) viol++;
            if (rsp_valid) begin
                done = 1;
                if (ctr_load || ctr_count_en || ctr_up_down) viol++;
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        abort = 1'b0;
        check({tag, ".finished"}, done, 1);
        check({tag, ".done_cycle"}, c, v.done);
        check({tag, ".strobes"}, strobes, v.strobes);
        check({tag, ".loads"}, loads, (v.op == LOAD) ? 1 : 0);
        check({tag, ".protocol"}, viol, 0);
        check({tag, ".rsp_val"}, rsp_val, v.val);
        check({tag, ".rsp_wraps"}, rsp_wraps, v.wraps);
        check({tag, ".rsp_aborted"}, rsp_aborted, v.aborted);
        snap = {rsp_val, rsp_wraps, rsp_aborted};
        for (int i = 0; i < v.ready_delay; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_arg = 16'($urandom_range(0, 9));
            abort = 1'($urandom);
            @(negedge clk);
            check({tag, ".pending"},
                  {rsp_valid, cmd_ready, ctr_count_en, ctr_load, rsp_val, rsp_wraps, rsp_aborted},
                  {4'b1000, snap});
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; abort = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, ".held"}, {rsp_valid, rsp_val, rsp_wraps, rsp_aborted}, {1'b1, snap});
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, ".idle_after"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    function automatic vec_t mk(input logic [1:0] op, input int arg, input int abort_at,
                                input int rd, input int val, input int wraps, input int ab,
                                input int strobes, input int done);
        vec_t v;
        v.op = op; v.arg = 16'(arg); v.abort_at = abort_at; v.ready_delay = rd;
        v.val = 8'(val); v.wraps = 4'(wraps); v.aborted = 1'(ab);
        v.strobes = strobes; v.done = done;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        int   model;
        int   n, steps;
        vec_t v;
        int   seen_rsp, seen_en;

        //            op    arg     ab  rd  val   w   ab  strb  done
        vecs.push_back(mk(LOAD, 'hF0,    0, 0, 'hF0, 0, 0,    0,    2));
        vecs.push_back(mk(UP,   5,       0, 1, 'hF5, 0, 0,    5,    6));
        vecs.push_back(mk(LOAD, 'hFE,    0, 0, 'hFE, 0, 0,    0,    2));
        vecs.push_back(mk(UP,   4,       0, 0, 'h02, 1, 0,    4,    5));
        vecs.push_back(mk(LOAD, 'h01,    0, 0, 'h01, 0, 0,    0,    2));
        vecs.push_back(mk(DOWN, 3,       0, 2, 'hFE, 1, 0,    3,    4));
        vecs.push_back(mk(LOAD, 'h00,    0, 0, 'h00, 0, 0,    0,    2));
        vecs.push_back(mk(UP,   600,     0, 0, 'h58, 2, 0,  600,  601));
        vecs.push_back(mk(UP,   0,       0, 0, 'h58, 0, 0,    0,    1));
        vecs.push_back(mk(WAIT, 0,       0, 0, 'h58, 0, 0,    0,    1));
        vecs.push_back(mk(LOAD, 'h10,    0, 0, 'h10, 0, 0,    0,    2));
        vecs.push_back(mk(UP,   100,    11, 0, 'h1A, 0, 1,   10,   12));
        vecs.push_back(mk(WAIT, 3,       0, 4, 'h1A, 0, 0,    0,    4));
        vecs.push_back(mk(LOAD, 'h1FE,   1, 0, 'hFE, 0, 0,    0,    2));
        vecs.push_back(mk(WAIT, 5,       2, 0, 'hFE, 0, 1,    0,    3));
        vecs.push_back(mk(UP,   4096,    0, 0, 'hFE, 15, 0, 4096, 4097));
        vecs.push_back(mk(DOWN, 2,       1, 1, 'hFE, 0, 1,    0,    2));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset.cmd_ready", cmd_ready, 1);
        check("reset.outputs",
              {rsp_valid, rsp_val, rsp_wraps, rsp_aborted, ctr_in_val, ctr_load, ctr_up_down, ctr_count_en},
              '0);

        // Reset in the middle of a long UP must drop the command without a response.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = UP; cmd_arg = 16'd50;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst.state", {ctr_count_en, rsp_valid, cmd_ready}, 3'b001);
        seen_rsp = 0; seen_en = 0;
        repeat (60) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp++;
            if (ctr_count_en || ctr_load) seen_en++;
        end
        check("midrst.no_rsp", seen_rsp, 0);
        check("midrst.no_strobe", seen_en, 0);

        foreach (vecs[i]) run_cmd($sformatf("vec%0d", i), vecs[i]);

        model = 'hFE;
        for (int k = 0; k < 40; k++) begin
            v.op = 2'($urandom);
            if (v.op == LOAD)
                v.arg = 16'($urandom);
            else
                v.arg = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 700)) : 16'($urandom_range(0, 12));
            n = (v.op == LOAD) ? 1 : int'(v.arg);
            v.abort_at = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, n + 2));
            v.ready_delay = $urandom_range(0, 3);
            v.aborted = 1'b0; v.wraps = '0; v.strobes = 0;
            if (v.op == LOAD) begin
                v.val = v.arg[7:0];
                v.done = 2;
            end else begin
                if (n == 0) begin
                    steps = 0; v.done = 1;
                end else if (v.abort_at >= 1 && v.abort_at <= n) begin
                    steps = v.abort_at - 1; v.done = v.abort_at + 1; v.aborted = 1'b1;
                end else begin
                    steps = n; v.done = n + 1;
                end
                if (v.op == WAIT) begin
                    v.val = 8'(model);
                end else begin
                    v.strobes = steps;
                    v.wraps = 4'(wraps_for(v.op, model, steps));
                    v.val = (v.op == UP) ? 8'(model + steps) : 8'(model - steps);
                end
            end
            model = int'(v.val);
            run_cmd($sformatf("rnd%0d", k), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
